// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: answers READ (0x03), READ STATUS (0x05) and JEDEC ID (0x9F)
// from an external byte-wide memory. All SPI inputs are oversampled in the clk_50M domain.
module spi_flash_responder #(
  parameter int          ADDR_W     = 16,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int RX_W = (ADDR_W > 8) ? ADDR_W : 8;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, STAT, ID, IGNORE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic              r_cs_s1, r_cs_s2;
  logic              r_mosi_s1, r_mosi_s2;
  logic [4:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [RX_W-2:0]   r_rx, w_rx_nxt;
  logic [RX_W-1:0]   w_rx_shift;
  logic [7:0]        r_tx, w_tx_nxt;
  logic              r_miso, w_miso_nxt;
  logic              r_mem_rd, w_mem_rd_nxt;
  logic              r_rd_d;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [1:0]        r_byte_idx, w_byte_idx_nxt;

  wire w_rise   = r_sclk_s2 & ~r_sclk_s3;
  wire w_fall   = ~r_sclk_s2 & r_sclk_s3;
  wire w_cs_act = ~r_cs_s2;

  // cs_n synchroniser resets to the deasserted level so the pad stays tristated in reset.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_rd_d     <= 1'b0;
      r_mem_addr <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_rx       <= w_rx_nxt;
      r_tx       <= w_tx_nxt;
      r_miso     <= w_miso_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_rd_d     <= r_mem_rd;
      r_mem_addr <= w_mem_addr_nxt;
      r_byte_idx <= w_byte_idx_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_nxt       = r_rx;
    w_tx_nxt       = r_tx;
    w_miso_nxt     = r_miso;
    w_mem_rd_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_byte_idx_nxt = r_byte_idx;
    w_rx_shift     = {r_rx, r_mosi_s2};

    if (r_rd_d && r_state == DATA) w_tx_nxt = mem_rdata;

    // Deselect wins over everything, including a prefetch decided on this very edge.
    if (!w_cs_act && r_state != IDLE) begin
      w_state_nxt   = IDLE;
      w_bit_cnt_nxt = '0;
      w_miso_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_miso_nxt = 1'b0;
          if (w_cs_act) begin
            w_state_nxt   = CMD;
            w_bit_cnt_nxt = '0;
          end
        end
        CMD: if (w_rise) begin
          w_rx_nxt = w_rx_shift[RX_W-2:0];
          if (r_bit_cnt == 5'd7) begin
            w_bit_cnt_nxt = '0;
            unique case (w_rx_shift[7:0])
              8'h03: w_state_nxt = ADDR;
              8'h05: begin
                w_state_nxt = STAT;
                w_tx_nxt    = STATUS_VAL;
              end
              8'h9F: begin
                w_state_nxt    = ID;
                w_tx_nxt       = JEDEC_ID[23:16];
                w_byte_idx_nxt = '0;
              end
              default: w_state_nxt = IGNORE;
            endcase
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        ADDR: if (w_rise) begin
          w_rx_nxt = w_rx_shift[RX_W-2:0];
          if (r_bit_cnt == 5'd23) begin
            w_bit_cnt_nxt  = '0;
            w_mem_addr_nxt = w_rx_shift[ADDR_W-1:0];
            w_mem_rd_nxt   = 1'b1;
            w_state_nxt    = DATA;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        DATA, STAT, ID: begin
          if (w_fall) begin
            w_miso_nxt = r_tx[7];
            w_tx_nxt   = {r_tx[6:0], 1'b0};
          end
          // The reload on the 8th rise lands well before the next fall given the SCLK low time.
          if (w_rise) begin
            if (r_bit_cnt == 5'd7) begin
              w_bit_cnt_nxt = '0;
              if (r_state == DATA) begin
                w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
                w_mem_rd_nxt   = 1'b1;
              end else if (r_state == STAT) begin
                w_tx_nxt = STATUS_VAL;
              end else begin
                unique case (r_byte_idx)
                  2'd0: begin
                    w_tx_nxt       = JEDEC_ID[15:8];
                    w_byte_idx_nxt = 2'd1;
                  end
                  2'd1: begin
                    w_tx_nxt       = JEDEC_ID[7:0];
                    w_byte_idx_nxt = 2'd2;
                  end
                  default: begin
                    w_tx_nxt       = 8'h00;
                    w_byte_idx_nxt = 2'd3;
                  end
                endcase
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 5'd1;
            end
          end
        end
        IGNORE: w_miso_nxt = 1'b0;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = w_cs_act;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign busy        = w_cs_act && (r_state != IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a mode-0 master at 5 MHz SCLK and a memory
// that returns the low byte of its address one cycle after each read strobe.
module tb_spi_flash_responder;

  localparam int ADDR_W = 16;

  logic              clk_50M = 1'b0;
  logic              rst;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  logic [ADDR_W-1:0] rd_log[$];

  spi_flash_responder #(.ADDR_W(ADDR_W)) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) begin
    if (mem_rd) mem_rdata <= mem_addr[7:0];
    if (!rst && mem_rd) begin
      rd_cnt = rd_cnt + 1;
      rd_log.push_back(mem_addr);
    end
  end

  // One SCLK period (200 ns): drive MOSI while low, sample MISO at the rise, then fall.
  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    #100 spi_sclk = 1'b1;
    r = spi_miso;
    #100 spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_low();
    @(negedge clk_50M);
    spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100 spi_cs_n = 1'b1;
    repeat (10) @(negedge clk_50M);
  endtask

  task automatic clear_log();
    rd_cnt = 0;
    rd_log.delete();
  endtask

  task automatic send_read(input logic [23:0] a);
    logic [7:0] d;
    spi_byte(8'h03, d);
    spi_byte(a[23:16], d);
    spi_byte(a[15:8], d);
    spi_byte(a[7:0], d);
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk_50M);
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk_50M);
  endtask

  task automatic test_read_stream();
    logic [7:0] d0, d1, d2;
    int n1234;
    clear_log();
    cs_low();
    send_read(24'h001234);
    spi_byte(8'h00, d0);
    spi_byte(8'h00, d1);
    spi_byte(8'h00, d2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy got=%b exp=1", busy); end
    total++; if (spi_miso_oe !== 1'b1) begin bad++; $display("FAIL read_oe got=%b exp=1", spi_miso_oe); end
    cs_high();
    total++; if ({d0, d1, d2} !== 24'h343536) begin bad++; $display("FAIL read_data got=%h exp=343536", {d0, d1, d2}); end
    n1234 = 0;
    foreach (rd_log[i]) if (rd_log[i] == 16'h1234) n1234++;
    total++; if (n1234 !== 1) begin bad++; $display("FAIL read_one_1234 got=%0d exp=1", n1234); end
    total++;
    if (rd_log.size() < 3) begin bad++; $display("FAIL read_addr_seq got_count=%0d exp>=3", rd_log.size()); end
    else if ({rd_log[0], rd_log[1], rd_log[2]} !== 48'h1234_1235_1236) begin
      bad++; $display("FAIL read_addr_seq got=%h %h %h exp=1234 1235 1236", rd_log[0], rd_log[1], rd_log[2]);
    end
    total++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin bad++; $display("FAIL read_end busy=%b oe=%b exp=0 0", busy, spi_miso_oe); end
  endtask

  task automatic test_wrap();
    logic [7:0] d0, d1;
    clear_log();
    cs_low();
    send_read(24'h00FFFF);
    spi_byte(8'h00, d0);
    spi_byte(8'h00, d1);
    cs_high();
    total++; if ({d0, d1} !== 16'hFF00) begin bad++; $display("FAIL wrap_data got=%h exp=ff00", {d0, d1}); end
    total++;
    if (rd_log.size() < 2) begin bad++; $display("FAIL wrap_addr got_count=%0d exp>=2", rd_log.size()); end
    else if ({rd_log[0], rd_log[1]} !== 32'hFFFF_0000) begin
      bad++; $display("FAIL wrap_addr got=%h %h exp=ffff 0000", rd_log[0], rd_log[1]);
    end
  endtask

  task automatic test_jedec();
    logic [7:0] d, b0, b1, b2, b3;
    clear_log();
    cs_low();
    spi_byte(8'h9F, d);
    spi_byte(8'hFF, b0);
    spi_byte(8'hFF, b1);
    spi_byte(8'hFF, b2);
    spi_byte(8'hFF, b3);
    cs_high();
    total++; if ({b0, b1, b2, b3} !== 32'hEF401600) begin bad++; $display("FAIL jedec_data got=%h exp=ef401600", {b0, b1, b2, b3}); end
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL jedec_no_rd got=%0d exp=0", rd_cnt); end
  endtask

  task automatic test_status_ignore();
    logic [7:0] d, s0, s1, g0, g1;
    clear_log();
    cs_low();
    spi_byte(8'h05, d);
    spi_byte(8'hA5, s0);
    spi_byte(8'h5A, s1);
    cs_high();
    total++; if ({s0, s1} !== 16'h0000) begin bad++; $display("FAIL status_data got=%h exp=0000", {s0, s1}); end
    cs_low();
    spi_byte(8'hAB, d);
    spi_byte(8'hFF, g0);
    spi_byte(8'hFF, g1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    cs_high();
    total++; if ({g0, g1} !== 16'h0000) begin bad++; $display("FAIL ignore_miso got=%h exp=0000", {g0, g1}); end
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL ignore_no_rd got=%0d exp=0", rd_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic r;
    clear_log();
    cs_low();
    spi_byte(8'h03, d);
    for (int i = 0; i < 13; i++) spi_bit(1'b1, r);
    cs_high();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b exp=0", busy); end
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL abort_no_rd got=%0d exp=0", rd_cnt); end
    clear_log();
    cs_low();
    send_read(24'h000010);
    spi_byte(8'h00, d);
    cs_high();
    total++; if (d !== 8'h10) begin bad++; $display("FAIL abort_reread got=%h exp=10", d); end
    total++;
    if (rd_log.size() < 1) begin bad++; $display("FAIL abort_reread_addr got_count=0 exp>=1"); end
    else if (rd_log[0] !== 16'h0010) begin bad++; $display("FAIL abort_reread_addr got=%h exp=0010", rd_log[0]); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic r;
    clear_log();
    cs_low();
    send_read(24'h000020);
    spi_byte(8'h00, d);
    total++; if (d !== 8'h20) begin bad++; $display("FAIL rst_pre_data got=%h exp=20", d); end
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    @(negedge clk_50M);
    #3 rst = 1'b1;
    #40;
    total++; if (spi_miso_oe !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_outputs oe=%b busy=%b exp=0 0", spi_miso_oe, busy); end
    total++; if (spi_miso !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0) begin
      bad++; $display("FAIL rst_outputs2 miso=%b rd=%b addr=%h exp=0 0 0000", spi_miso, mem_rd, mem_addr);
    end
    @(negedge clk_50M);
    rst = 1'b0;
    repeat (8) @(negedge clk_50M);
    total++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin bad++; $display("FAIL rst_to_cmd busy=%b oe=%b exp=1 1", busy, spi_miso_oe); end
    spi_byte(8'h9F, d);
    spi_byte(8'h00, d);
    cs_high();
    total++; if (d !== 8'hEF) begin bad++; $display("FAIL rst_cmd_decode got=%h exp=ef", d); end
  endtask

  initial begin
    test_reset();
    test_read_stream();
    test_wrap();
    test_jedec();
    test_status_ignore();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI flash target emulating the serial-configuration flash that the board's flash master port (nCSO/DCLK/ASDO/DATA0) talks to.
- Lets a board-to-board or loopback setup exercise that master without a real device.
- Decodes READ (0x03), READ STATUS (0x05) and READ JEDEC ID (0x9F) in SPI mode 0.
- Read data comes from an external byte-wide memory port. All SPI inputs are oversampled in the clk_50M domain.

Parameters:
- ADDR_W, 16: memory address width; the low ADDR_W bits of the 24-bit SPI address are used.
- JEDEC_ID, 24'hEF4016: three bytes returned by 0x9F, MSB byte first.
- STATUS_VAL, 8'h00: byte returned by 0x05, repeated while CS is held.

Ports:
- clk_50M, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- spi_sclk, input, 1: SPI clock from master, asynchronous to clk_50M.
- spi_cs_n, input, 1: chip select, active low.
- spi_mosi, input, 1: master data out.
- spi_miso, output, 1: responder data out.
- spi_miso_oe, output, 1: MISO output enable, for the pad tristate.
- mem_rd, output, 1: one-cycle read strobe.
- mem_addr, output, ADDR_W: read address, valid while mem_rd is high.
- mem_rdata, input, 8: read data, valid exactly 1 clk_50M cycle after mem_rd.
- busy, output, 1: high while a transaction is in progress (CS low and not in IDLE).

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, mem_rd=0, mem_addr=0, busy=0, state IDLE, all shift and bit counters 0. Reset is accepted at any time, including mid-transaction.
- Input synchronisation: sclk, cs_n and mosi each pass a 2-flop synchroniser.
  - Rise and fall events come from a third sclk stage.
  - Required: SCLK high and low times of at least 4 clk_50M cycles each (SCLK ≤ 6.25 MHz).
- Mode 0 timing: MOSI is sampled on SCLK rise events; MISO changes on SCLK fall events. Bits are MSB first.
- spi_miso_oe equals the synchronised CS asserted, in every state. spi_miso is 0 whenever no data is being shifted.
- States:
  - IDLE: wait for synchronised cs_n=0, then go to CMD with the bit counter cleared.
  - CMD: shift 8 bits. On the 8th rise, decode:
    - 0x03 → ADDR.
    - 0x05 → STAT; load STATUS_VAL into the TX shift register.
    - 0x9F → ID; load JEDEC_ID[23:16] and set the byte index to 0.
    - any other value → IGNORE.
  - ADDR: shift 24 bits. On the 24th rise, set mem_addr to addr[ADDR_W-1:0], pulse mem_rd for 1 cycle, then go to DATA.
  - DATA:
    - The TX shift register loads mem_rdata on the cycle after mem_rd.
    - Bit 7 drives MISO on the next fall; each later fall shifts left.
    - On the 8th rise of each data byte, increment mem_addr (wrapping modulo 2^ADDR_W) and pulse mem_rd; the new byte loads before the next fall.
    - Streaming continues indefinitely.
  - STAT: STATUS_VAL repeats every byte.
  - ID: bytes 23:16, 15:8, 7:0, then 0x00 for every later byte.
  - IGNORE: MISO held 0, no mem_rd.
- Command and response overlap: the first response bit is driven on the first fall after the last command/address rise, so there are no dummy cycles.
- CS deassert (synchronised cs_n=1) in any state:
  - Return to IDLE next cycle and clear the bit counter.
  - Partial bytes are discarded.
  - No further mem_rd is issued, including a prefetch already decided but not yet strobed.
- Extra MOSI bits during DATA/STAT/ID/IGNORE are ignored.
- A CS glitch shorter than the synchroniser depth may be missed; this is not required to be handled.

Test Plan:
- READ stream: CS low, send 0x03 plus address 0x001234 at SCLK=5 MHz. Memory returns (addr & 0xFF).
  - Required: exactly one mem_rd with mem_addr=0x1234, then 0x1235, 0x1236.
  - Required: MISO bytes 0x34, 0x35, 0x36.
- Address wrap: READ at 0x00FFFF for 2 bytes. Required: mem_addr sequence 0xFFFF, then 0x0000.
- JEDEC ID: send 0x9F and clock 4 bytes. Required: MISO bytes 0xEF, 0x40, 0x16, 0x00; mem_rd never asserted.
- Status and unknown command:
  - 0x05 for 2 bytes → required 0x00, 0x00.
  - New transaction with 0xAB → required MISO=0 for 16 SCLKs, no mem_rd, busy=1 until CS rises.
- Abort: raise CS after 13 address bits, then start a fresh READ of 0x000010.
  - Required: return to IDLE, no mem_rd during the aborted transaction.
  - Required: second transaction returns memory byte 0x10 correctly.
- Async reset: assert rst mid-DATA stream (CS still low), then release.
  - Required during reset: outputs at reset values (spi_miso_oe=0, busy=0).
  - Required after release with CS still low: goes to CMD, and the next 8 bits are decoded as a command.
